// File: rtl/cnt_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_rst_sequencer
//  Purpose  : Turns the rst_req bit of the cnt_rst software register word into
//             a clean, stretched counter-reset pulse followed by an optional
//             settle window. Maintains a sample counter of din_valid strobes
//             that the pulse clears, and reports busy / wrap / reset-count
//             status back toward software.
//  Ports    : user_clk      - sole clock (register word already synchronous)
//             user_rst_n    - asynchronous active-low reset
//             user_data_out - register word: [0] rst_req, [1] cnt_en,
//                             [15:8] settle_len, [31:16] pulse_len
//             din_valid     - sample strobe, one count per high cycle
//             cnt_rst       - registered active-high counter reset
//             busy          - high while in PULSE or SETTLE
//             cnt_out       - counted strobes since the last reset pulse
//             cnt_wrap      - sticky flag, set when cnt_out wraps
//             rst_count     - number of pulses issued (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module cnt_rst_sequencer #(
  parameter int CNT_W  = 32,
  parameter int RCNT_W = 8
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       user_data_out,
  input  logic              din_valid,
  output logic              cnt_rst,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_wrap,
  output logic [RCNT_W-1:0] rst_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RCNT_W-1:0] RCNT_ONE = {{(RCNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] reg_q;
  logic        rq_d;
  logic        pend;
  logic [15:0] pulse_cnt;     // remaining PULSE cycles, including the current one
  logic [7:0]  settle_len_q;  // settle length captured at PULSE entry
  logic [7:0]  settle_cnt;    // remaining SETTLE cycles, including the current one

  logic        req_edge;
  logic [15:0] pulse_len_eff;
  logic        launch;
  logic        count_inc;

  // Bits [7:2] of the register word carry no meaning for this block.
  logic unused_reg_bits;
  assign unused_reg_bits = &{1'b0, reg_q[7:2]};

  assign req_edge      = reg_q[0] & ~rq_d;
  assign pulse_len_eff = (reg_q[31:16] == 16'd0) ? 16'd1 : reg_q[31:16];

  // launch: the FSM enters PULSE on this edge. A queued request re-enters
  // PULSE straight from the final PULSE/SETTLE cycle so back-to-back
  // sequences have no IDLE cycle between them.
  always_comb begin
    launch = 1'b0;
    case (state)
      ST_IDLE:   launch = req_edge | pend;
      ST_PULSE:  launch = (pulse_cnt == 16'd1) && (settle_len_q == 8'd0) && pend;
      ST_SETTLE: launch = (settle_cnt == 8'd1) && pend;
      default:   launch = 1'b0;
    endcase
  end

  // A strobe coincident with the IDLE->PULSE transition is not counted.
  assign count_inc = (state == ST_IDLE) && !launch && reg_q[1] && din_valid;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state        <= ST_IDLE;
      reg_q        <= 32'd0;
      rq_d         <= 1'b0;
      pend         <= 1'b0;
      pulse_cnt    <= 16'd0;
      settle_len_q <= 8'd0;
      settle_cnt   <= 8'd0;
      cnt_rst      <= 1'b0;
      busy         <= 1'b0;
      cnt_out      <= '0;
      cnt_wrap     <= 1'b0;
      rst_count    <= '0;
    end else begin
      reg_q <= user_data_out;
      rq_d  <= reg_q[0];

      if (launch) begin
        state        <= ST_PULSE;
        cnt_rst      <= 1'b1;
        busy         <= 1'b1;
        pulse_cnt    <= pulse_len_eff;
        settle_len_q <= reg_q[15:8];
        cnt_out      <= '0;
        cnt_wrap     <= 1'b0;
        rst_count    <= rst_count + RCNT_ONE;
        pend         <= 1'b0;
      end else begin
        // Only one request is queued; later edges simply re-set the flag.
        if ((state != ST_IDLE) && req_edge) begin
          pend <= 1'b1;
        end

        if (count_inc) begin
          cnt_out <= cnt_out + CNT_ONE;
          if (&cnt_out) begin
            cnt_wrap <= 1'b1;
          end
        end

        case (state)
          ST_IDLE: begin
          end
          ST_PULSE: begin
            if (pulse_cnt == 16'd1) begin
              cnt_rst <= 1'b0;
              if (settle_len_q != 8'd0) begin
                state      <= ST_SETTLE;
                settle_cnt <= settle_len_q;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              pulse_cnt <= pulse_cnt - 16'd1;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == 8'd1) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt - 8'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            cnt_rst <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnt_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnt_rst_sequencer
//  Purpose  : Self-checking bench for cnt_rst_sequencer. Two instances share
//             the stimulus: one with a 32-bit sample counter, one with a
//             4-bit counter so that wrap behaviour is reachable. A
//             cycle-level reference model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_rst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = 32'd0;
  logic        din = 1'b0;

  logic        cnt_rst_a, busy_a, wrap_a;
  logic [31:0] cnt_a;
  logic [7:0]  rc_a;
  logic        cnt_rst_b, busy_b, wrap_b;
  logic [3:0]  cnt_b;
  logic [7:0]  rc_b;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_reg;
  logic        m_rq, m_pend, m_wrap, m_wrap4;
  logic [31:0] m_cnt;
  int          m_cnt4, m_rcnt, m_prem, m_srem, m_ssave;

  // window statistics taken from the 32-bit instance
  int  n_rst_hi, n_busy_hi, n_rises, n_busy_falls;
  logic p_rst, p_busy;

  int rc_base;

  always #5 clk = ~clk;

  cnt_rst_sequencer #(.CNT_W(32), .RCNT_W(8)) u_dut_a (
    .user_clk(clk), .user_rst_n(rst_n), .user_data_out(word), .din_valid(din),
    .cnt_rst(cnt_rst_a), .busy(busy_a), .cnt_out(cnt_a), .cnt_wrap(wrap_a),
    .rst_count(rc_a)
  );

  cnt_rst_sequencer #(.CNT_W(4), .RCNT_W(8)) u_dut_b (
    .user_clk(clk), .user_rst_n(rst_n), .user_data_out(word), .din_valid(din),
    .cnt_rst(cnt_rst_b), .busy(busy_b), .cnt_out(cnt_b), .cnt_wrap(wrap_b),
    .rst_count(rc_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reg = 32'd0; m_rq = 1'b0; m_pend = 1'b0;
    m_cnt = 32'd0; m_wrap = 1'b0; m_cnt4 = 0; m_wrap4 = 1'b0;
    m_rcnt = 0; m_prem = 0; m_srem = 0; m_ssave = 0;
  endtask

  // One rising edge of the specification's behaviour, using the inputs that
  // are present at that edge.
  task automatic model_step();
    bit e, idle, start;
    e     = m_reg[0] && !m_rq;
    idle  = (m_prem == 0) && (m_srem == 0);
    start = 1'b0;
    if (idle)
      start = e || m_pend;
    else if (m_prem == 1 && m_ssave == 0)
      start = m_pend;               // queued request, no settle window
    else if (m_prem == 0 && m_srem == 1)
      start = m_pend;               // queued request after settle
    if (start) begin
      m_cnt = 32'd0; m_wrap = 1'b0; m_cnt4 = 0; m_wrap4 = 1'b0;
      m_rcnt = (m_rcnt + 1) % 256;
      m_pend = 1'b0;
      m_prem = (m_reg[31:16] == 16'd0) ? 1 : int'(m_reg[31:16]);
      m_ssave = int'(m_reg[15:8]);
      m_srem = 0;
    end else begin
      if (!idle && e) m_pend = 1'b1;
      if (idle && m_reg[1] && din) begin
        if (m_cnt == 32'hFFFF_FFFF) m_wrap = 1'b1;
        m_cnt = m_cnt + 32'd1;
        m_cnt4 = (m_cnt4 + 1) % 16;
        if (m_cnt4 == 0) m_wrap4 = 1'b1;
      end
      if (m_prem > 0) begin
        m_prem--;
        if (m_prem == 0) m_srem = m_ssave;
      end else if (m_srem > 0) begin
        m_srem--;
      end
    end
    m_rq  = m_reg[0];
    m_reg = word;
  endtask

  task automatic compare_all();
    check("cnt_rst",     {31'd0, cnt_rst_a}, {31'd0, m_prem > 0});
    check("busy",        {31'd0, busy_a},    {31'd0, (m_prem > 0) || (m_srem > 0)});
    check("cnt_out",     cnt_a,              m_cnt);
    check("cnt_wrap",    {31'd0, wrap_a},    {31'd0, m_wrap});
    check("rst_count",   {24'd0, rc_a},      32'(m_rcnt));
    check("cnt_rst_w4",  {31'd0, cnt_rst_b}, {31'd0, m_prem > 0});
    check("busy_w4",     {31'd0, busy_b},    {31'd0, (m_prem > 0) || (m_srem > 0)});
    check("cnt_out_w4",  {28'd0, cnt_b},     32'(m_cnt4));
    check("cnt_wrap_w4", {31'd0, wrap_b},    {31'd0, m_wrap4});
    check("rst_count_w4",{24'd0, rc_b},      32'(m_rcnt));
  endtask

  task automatic clear_stats();
    n_rst_hi = 0; n_busy_hi = 0; n_rises = 0; n_busy_falls = 0;
    p_rst = cnt_rst_a; p_busy = busy_a;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
    if (cnt_rst_a) n_rst_hi++;
    if (busy_a) n_busy_hi++;
    if (cnt_rst_a && !p_rst) n_rises++;
    if (!busy_a && p_busy) n_busy_falls++;
    p_rst = cnt_rst_a; p_busy = busy_a;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    clear_stats();
    // power-on reset
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    // basic pulse: L=4, S=3, held request bit gives one pulse only
    word = 32'h0004_0300; tick();
    clear_stats();
    word = 32'h0004_0301;
    ticks(20);
    check("basic_rst_cycles",  32'(n_rst_hi),  32'd4);
    check("basic_busy_cycles", 32'(n_busy_hi), 32'd7);
    check("basic_pulses",      32'(n_rises),   32'd1);
    check("basic_rst_count",   {24'd0, rc_a},  32'd1);

    // zero lengths: 1-cycle pulse, no settle
    word = 32'h0000_0000; tick();
    clear_stats();
    word = 32'h0000_0001;
    ticks(6);
    check("zero_rst_cycles",  32'(n_rst_hi),  32'd1);
    check("zero_busy_cycles", 32'(n_busy_hi), 32'd1);
    check("zero_idle",        {31'd0, busy_a}, 32'd0);

    // counting and gating
    word = 32'h0000_0002; ticks(2);
    din = 1'b1; ticks(100);
    din = 1'b0; tick();
    check("count_100",     cnt_a,            32'd100);
    check("count_100_w4",  {28'd0, cnt_b},   32'd4);
    check("wrap_w4_set",   {31'd0, wrap_b},  32'd1);
    check("wrap_32_clear", {31'd0, wrap_a},  32'd0);
    word = 32'h0000_0000; ticks(2);
    din = 1'b1; ticks(10);
    din = 1'b0; tick();
    check("gated_count", cnt_a, 32'd100);

    // strobes during PULSE/SETTLE are held; request clears the count
    word = 32'h0006_0502; din = 1'b1; tick();
    word = 32'h0006_0503; ticks(8);
    check("held_busy",  {31'd0, busy_a}, 32'd1);
    check("held_count", cnt_a,           32'd0);
    ticks(12);
    din = 1'b0; tick();

    // queuing: L=8, S=4, three more rising edges inside PULSE
    word = 32'h0008_0400; tick();
    rc_base = m_rcnt;
    clear_stats();
    word = 32'h0008_0401; ticks(2);
    for (int i = 0; i < 3; i++) begin
      word = 32'h0008_0400; tick();
      word = 32'h0008_0401; tick();
    end
    ticks(40);
    check("queue_pulses",      32'(n_rises),      32'd2);
    check("queue_rst_cycles",  32'(n_rst_hi),     32'd16);
    check("queue_busy_cycles", 32'(n_busy_hi),    32'd24);
    check("queue_no_gap",      32'(n_busy_falls), 32'd1);
    check("queue_rst_count",   {24'd0, rc_a},     32'((rc_base + 2) % 256));

    // wrap with the 4-bit instance: 17 strobes after a clearing pulse
    word = 32'h0001_0002; tick();
    word = 32'h0001_0003; ticks(4);
    din = 1'b1; ticks(17);
    din = 1'b0; tick();
    check("wrap17_cnt_w4",  {28'd0, cnt_b},  32'd1);
    check("wrap17_flag_w4", {31'd0, wrap_b}, 32'd1);
    check("wrap17_cnt_32",  cnt_a,           32'd17);
    word = 32'h0001_0002; tick();
    word = 32'h0001_0003; ticks(3);
    check("wrap_cleared_cnt",  {28'd0, cnt_b},  32'd0);
    check("wrap_cleared_flag", {31'd0, wrap_b}, 32'd0);

    // asynchronous reset in the middle of a long pulse
    word = 32'h0020_0000; tick();
    word = 32'h0020_0001; ticks(5);
    check("pre_reset_pulse", {31'd0, cnt_rst_a}, 32'd1);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_cnt_rst",   {31'd0, cnt_rst_a}, 32'd0);
    check("rst_busy",      {31'd0, busy_a},    32'd0);
    check("rst_cnt_out",   cnt_a,              32'd0);
    check("rst_cnt_wrap",  {31'd0, wrap_b},    32'd0);
    check("rst_rst_count", {24'd0, rc_a},      32'd0);
    word = 32'h0000_0000;
    ticks(3);
    rst_n = 1'b1;
    ticks(5);
    check("post_reset_idle", {24'd0, rc_a}, 32'd0);

    // request bit already set when reset is released
    rst_n = 1'b0; #1; model_reset();
    word = 32'h0002_0001;
    ticks(2);
    rst_n = 1'b1;
    clear_stats();
    ticks(10);
    check("release_pulses",    32'(n_rises),  32'd1);
    check("release_rst_count", {24'd0, rc_a}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      din = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        word = {16'($urandom_range(0, 5)), 8'($urandom_range(0, 4)), 6'd0,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))};
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
